// File: rtl/inv_mix_columns_if.sv
// Valid/ready/data bundle carrying one 128-bit AES state.
// The producer side uses master, the consumer side uses slave.
interface inv_mix_columns_if;
    logic         valid;
    logic         ready;
    logic [127:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// The state is transformed in place and held until the consumer takes it.
module inv_mix_columns #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    inv_mix_columns_if.slave  in_if,
    inv_mix_columns_if.master out_if,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

    state_t       state;
    logic [2:0]   cnt;
    logic [127:0] st;
    logic [127:0] st_nxt;
    logic         rdy_q;
    logic         ov_q;
    logic         busy_q;
    logic         last;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // k selects which of b, 2b, 4b, 8b are summed
    function automatic logic [7:0] gm(
        input logic [7:0] b,
        input logic [3:0] k
    );
        logic [7:0] b2;
        logic [7:0] b4;
        logic [7:0] b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        return (k[0] ? b  : 8'h00) ^ (k[1] ? b2 : 8'h00) ^
               (k[2] ? b4 : 8'h00) ^ (k[3] ? b8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {
            gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)
        };
    endfunction

    always_comb begin
        st_nxt = st;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            int c;
            c = (int'(cnt) + j) & 3;
            st_nxt[127 - 32*c -: 32] = inv_col(st[127 - 32*c -: 32]);
        end
    end

    assign last = (4'(cnt) + 4'(STEP)) >= 4'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            st     <= '0;
            rdy_q  <= 1'b1;
            ov_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_if.valid) begin
                        st     <= in_if.data;
                        cnt    <= '0;
                        state  <= CALC;
                        rdy_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                CALC: begin
                    st  <= st_nxt;
                    cnt <= cnt + STEP;
                    if (last) begin
                        state <= DONE;
                        ov_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_if.ready) begin
                        state  <= IDLE;
                        ov_q   <= 1'b0;
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_if.ready  = rdy_q;
    assign out_if.valid = ov_q;
    assign out_if.data  = ov_q ? st : '0;
    assign busy         = busy_q;

endmodule
